// File: rtl/odd_up_down_counter.sv
// odd_up_down_counter: odd-only up/down counter (1..2^WIDTH-1); define ODD_COUNTER_SATURATE_EN to saturate instead of wrap
module odd_up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Y,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);
  logic [WIDTH-2:0] k, k_next;
  logic             wrap_next, at_max, at_min;
  always_comb begin
    at_max = &k;
    at_min = ~|k;
`ifdef ODD_COUNTER_SATURATE_EN
    k_next    = Y ? (at_max ? k : k + 1'b1) : (at_min ? k : k - 1'b1);
    wrap_next = 1'b0;
`else
    k_next    = Y ? k + 1'b1 : k - 1'b1;
    wrap_next = Y ? at_max : at_min;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      k    <= '0;
      wrap <= 1'b0;
    end else begin
      k    <= k_next;
      wrap <= wrap_next;
    end
  end
  assign out = {k, 1'b1};
endmodule

// File: tb/tb_odd_up_down_counter.sv
// tb_odd_up_down_counter: directed checks of the odd up/down counter at WIDTH=4
module tb_odd_up_down_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Y = 1'b0;
  logic [3:0] out;
  logic       wrap;
  int         checks = 0;
  int         errors = 0;

  odd_up_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .Y(Y), .out(out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic y);
    reset = r;
    Y     = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ODD_COUNTER_SATURATE_EN
    int sat_up[10]   = '{3, 5, 7, 9, 11, 13, 15, 15, 15, 15};
    int sat_down[10] = '{13, 11, 9, 7, 5, 3, 1, 1, 1, 1};
`else
    int up_exp[9]   = '{3, 5, 7, 9, 11, 13, 15, 1, 3};
    int down_exp[9] = '{15, 13, 11, 9, 7, 5, 3, 1, 15};
`endif
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      check("reset_out", out, 1);
      check("reset_wrap", wrap, 0);
    end
`ifdef ODD_COUNTER_SATURATE_EN
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      check("sat_up_out", out, sat_up[i]);
      check("sat_up_wrap", wrap, 0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check("sat_down_out", out, sat_down[i]);
      check("sat_down_wrap", wrap, 0);
    end
`else
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1);
      check("up_out", out, up_exp[i]);
      check("up_wrap", wrap, (i == 7) ? 1 : 0);
    end
    step(1'b1, 1'b0);
    check("down_reset_out", out, 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0);
      check("down_out", out, down_exp[i]);
      check("down_wrap", wrap, (i == 0 || i == 8) ? 1 : 0);
    end
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("dir_up_out", out, 3 + 2 * i);
      check("dir_lsb", out[0], 1);
    end
    step(1'b0, 1'b0);
    check("dir_rev_out", out, 5);
    check("dir_lsb", out[0], 1);
    step(1'b0, 1'b0);
    check("dir_rev_out", out, 3);
    check("dir_rev_wrap", wrap, 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("mid_pre_out", out, 11);
    step(1'b1, 1'b1);
    check("mid_reset_out", out, 1);
    check("mid_reset_wrap", wrap, 0);
    step(1'b0, 1'b1);
    check("mid_release_out", out, 3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
